ball_controller: RTL and testbench
==================================

# ball_controller

Pong ball motion engine, upstream of the rectangle renderer: holds ball position and direction, advances them once per frame during vertical blanking, bounces off top/bottom walls and paddles, and reports missed balls as score pulses. Its `o_ball_x`/`o_ball_y` drive the renderer's rectangle-position inputs. The renderer instance's HEIGHT and WIDTH are both set to BALL_SIZE.

## Interface
- SCREEN_W, 640, active width in pixels
- SCREEN_H, 480, active height in pixels
- BALL_SIZE, 15, ball edge length in pixels
- PADDLE_W, 15, paddle width
- PADDLE_H, 100, paddle height
- LEFT_PADDLE_X, 20, left paddle x position (left edge)
- RIGHT_PADDLE_X, 605, right paddle x position (left edge)
- SPEED, 2, pixels moved per frame on each axis, 1..8
- SERVE_DELAY, 60, frames between serve request and motion

Ports:
- i_CLK  in  1  pixel clock
- i_RST  in  1  reset: asynchronous, active-high
- i_vSync  in  1  vertical sync from the timing generator, active-low
- i_serve  in  1  serve request, level, synchronous to i_CLK
- i_left_paddle_y  in  10  left paddle top edge
- i_right_paddle_y  in  10  right paddle top edge
- o_ball_x  out  10  ball left edge
- o_ball_y  out  10  ball top edge
- o_left_score  out  1  one-cycle pulse: left player won the point
- o_right_score  out  1  one-cycle pulse: right player won the point
- o_state  out  2  FSM state: 0 IDLE, 1 SERVE_WAIT, 2 PLAY

## Operation
- **Frame tick:** i_vSync is registered once. The tick is asserted for one cycle when the registered value is 1 and the current value is 0, i.e. on the falling edge.
- **Reset values:**
  - o_ball_x = (SCREEN_W−BALL_SIZE)/2 = 312
  - o_ball_y = (SCREEN_H−BALL_SIZE)/2 = 232
  - dir_x = right, dir_y = down
  - state IDLE, score pulses 0, serve counter 0
  - vSync history register = 1
- **IDLE:**
  - Ball is held at centre.
  - i_serve high on any cycle → SERVE_WAIT and the serve counter is cleared.
- **SERVE_WAIT:**
  - The counter increments on each tick.
  - When the counter reaches SERVE_DELAY → PLAY.
  - With SERVE_DELAY = 0, PLAY is entered on the next cycle.
  - i_serve is ignored.
- **PLAY, per tick:** all arithmetic is 11-bit unsigned, so there is no wrap. Paddle inputs are sampled on the tick cycle.
- **Y axis:**
  - Moving down and y+SPEED+BALL_SIZE ≥ SCREEN_H → y = SCREEN_H−BALL_SIZE, dir_y = up.
  - Moving up and y < SPEED → y = 0, dir_y = down.
  - Otherwise y ± SPEED.
- **X axis, moving left:**
  - Paddle hit when the ball's left edge crosses the left paddle face, i.e. x ≥ LEFT_PADDLE_X+PADDLE_W and x−SPEED < LEFT_PADDLE_X+PADDLE_W, and the ball overlaps the paddle vertically (y+BALL_SIZE > paddle_y and y < paddle_y+PADDLE_H).
  - On hit: x = LEFT_PADDLE_X+PADDLE_W, dir_x = right.
  - Else, if x < SPEED → miss: o_right_score pulses.
  - Else x −= SPEED.
- **X axis, moving right:**
  - Mirror of the left case. The paddle face is RIGHT_PADDLE_X, with crossing condition x+BALL_SIZE ≤ face < x+BALL_SIZE+SPEED.
  - On hit: x = RIGHT_PADDLE_X−BALL_SIZE.
  - Miss when x+BALL_SIZE+SPEED > SCREEN_W: o_left_score pulses.
- **Priority:** a paddle hit takes precedence over a miss. The y-wall and x-paddle responses may happen in the same tick (corner bounce).
- **On a miss:**
  - Ball is recentred and state → IDLE.
  - dir_x points toward the player who lost the point; dir_y toggles.
  - The y update for that tick is discarded.
- Ticks outside PLAY leave the position unchanged.

## Timing
- Position, state and score outputs are registered.
- Tick cycle = 1 cycle after the falling i_vSync sample. Outputs change on the clock edge that ends the tick cycle.
- Outputs are therefore stable for all of active video.
- At most one score pulse per frame; the two score pulses are never both high.
- i_serve to SERVE_WAIT: 1 cycle.
- i_RST mid-PLAY forces the reset values immediately (asynchronous), and any pending pulse is dropped.

## Structure
- **Package `pong_pkg`:** screen constants (640/480), BALL_SIZE and paddle geometry defaults, and state encodings (IDLE/SERVE_WAIT/PLAY) shared with the paddle controller and score logic.
- **Sub-module `frame_tick_gen`:** vSync edge detector with async-reset history flop, output `o_tick`. Reused by the paddle controller.

## Test plan
- **Reset:** assert i_RST mid-frame → ball (312,232), o_state 0, both score pulses 0, all within 0 cycles (asynchronous).
- **Serve:** i_serve for 1 cycle, SERVE_DELAY=3 → o_state=1 next cycle. PLAY after 3 ticks. 4th tick → ball (314,234).
- **Wall bounce:** with y=464, dir down → tick → y=465, dir up. Next tick → y=463.
- **Paddle hit:** left paddle y=200, ball x=36, y=240, moving left → tick → x=35, dir right. Next tick → x=37.
- **Miss:** left paddle y=0, ball x=1, y=300, moving left → o_right_score high exactly 1 cycle, ball (312,232), o_state 0, dir_x left.
- **Right-side miss:** ball x=624, moving right, right paddle y=0, ball y=300 → o_left_score pulse. No pulse on a tick in which an edge-crossing paddle hit occurs.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg
//   Shared Pong definitions: screen and geometry defaults, the game-state
//   encoding seen on o_state, direction encodings, and a vertical-overlap
//   helper used for paddle hit detection.
//   No ports (package).
package pong_pkg;

  localparam int PONG_SCREEN_W       = 640;
  localparam int PONG_SCREEN_H       = 480;
  localparam int PONG_BALL_SIZE      = 15;
  localparam int PONG_PADDLE_W       = 15;
  localparam int PONG_PADDLE_H       = 100;
  localparam int PONG_LEFT_PADDLE_X  = 20;
  localparam int PONG_RIGHT_PADDLE_X = 605;

  // Game-state encoding (visible on o_state)
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SERVE_WAIT = 2'd1,
    ST_PLAY       = 2'd2
  } game_state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_x_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_y_e;

  // True when the ball's rows [ball_top, ball_top+ball_size) intersect the
  // paddle's rows [paddle_top, paddle_top+paddle_h). 11-bit math cannot wrap
  // for 10-bit inputs and in-range geometry.
  function automatic logic rows_overlap(input logic [10:0] ball_top,
                                        input logic [10:0] paddle_top,
                                        input logic [10:0] ball_size,
                                        input logic [10:0] paddle_h);
    return ((ball_top + ball_size) > paddle_top) &&
           (ball_top < (paddle_top + paddle_h));
  endfunction

endpackage

// File: rtl/ball_controller_if.sv
// ball_controller_if
//   Bundles the frame-timing, serve, paddle and ball/score signals between
//   the game logic (master) and the ball controller (slave).
//   i_vSync           : vertical sync, active-low
//   i_serve           : serve request level
//   i_left/right_paddle_y : paddle top edges
//   o_ball_x/o_ball_y : ball top-left corner
//   o_left/right_score: one-cycle point pulses
//   o_state           : controller FSM state
interface ball_controller_if;
  import pong_pkg::*;

  logic       i_vSync;
  logic       i_serve;
  logic [9:0] i_left_paddle_y;
  logic [9:0] i_right_paddle_y;
  logic [9:0] o_ball_x;
  logic [9:0] o_ball_y;
  logic       o_left_score;
  logic       o_right_score;
  logic [1:0] o_state;

  modport master (
    output i_vSync, i_serve, i_left_paddle_y, i_right_paddle_y,
    input  o_ball_x, o_ball_y, o_left_score, o_right_score, o_state
  );

  modport slave (
    input  i_vSync, i_serve, i_left_paddle_y, i_right_paddle_y,
    output o_ball_x, o_ball_y, o_left_score, o_right_score, o_state
  );

endinterface

// File: rtl/frame_tick_gen.sv
// frame_tick_gen
//   Produces a one-cycle frame tick on the falling edge of the active-low
//   vertical sync. The history flop resets to 1 so that a vSync already low
//   when reset is released is seen as a fresh frame start.
//   i_CLK   : pixel clock
//   i_RST   : asynchronous active-high reset
//   i_vSync : vertical sync, active-low
//   o_tick  : high for the single cycle where history=1 and current=0
module frame_tick_gen (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_vSync,
  output logic o_tick
);

  logic vsync_q;

  // vSync history flop
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      vsync_q <= 1'b1;
    end else begin
      vsync_q <= i_vSync;
    end
  end

  assign o_tick = vsync_q & ~i_vSync;

endmodule

// File: rtl/ball_controller.sv
// ball_controller
//   Pong ball motion engine. Holds ball position and direction, advances
//   them once per frame tick while in PLAY, bounces off the top/bottom walls
//   and the paddle faces, and pulses a score output when a ball is missed.
//   i_CLK : pixel clock
//   i_RST : asynchronous active-high reset
//   bus   : slave side of ball_controller_if (vSync, serve, paddles in;
//           ball position, score pulses, state out). All outputs registered.
module ball_controller
  import pong_pkg::*;
#(
  parameter int SCREEN_W       = PONG_SCREEN_W,
  parameter int SCREEN_H       = PONG_SCREEN_H,
  parameter int BALL_SIZE      = PONG_BALL_SIZE,
  parameter int PADDLE_W       = PONG_PADDLE_W,
  parameter int PADDLE_H       = PONG_PADDLE_H,
  parameter int LEFT_PADDLE_X  = PONG_LEFT_PADDLE_X,
  parameter int RIGHT_PADDLE_X = PONG_RIGHT_PADDLE_X,
  parameter int SPEED          = 2,
  parameter int SERVE_DELAY    = 60
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  ball_controller_if.slave bus
);

  localparam int CNT_W = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY + 1);

  // All motion arithmetic is 11-bit so sums of 10-bit values never wrap.
  localparam logic [10:0] W_C      = 11'(SCREEN_W);
  localparam logic [10:0] H_C      = 11'(SCREEN_H);
  localparam logic [10:0] B_C      = 11'(BALL_SIZE);
  localparam logic [10:0] S_C      = 11'(SPEED);
  localparam logic [10:0] PH_C     = 11'(PADDLE_H);
  localparam logic [10:0] LFACE_C  = 11'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [10:0] RFACE_C  = 11'(RIGHT_PADDLE_X);
  localparam logic [9:0]  RSTOP_C  = 10'(RIGHT_PADDLE_X - BALL_SIZE);
  localparam logic [9:0]  X_CTR_C  = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]  Y_CTR_C  = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(SERVE_DELAY);

  game_state_e      state_q, state_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  dir_x_e           dir_x_q, dir_x_d;
  dir_y_e           dir_y_q, dir_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lscore_q, lscore_d, rscore_q, rscore_d;

  logic             tick;
  logic [10:0]      x_w, y_w, lpy_w, rpy_w;
  logic [9:0]       y_step;
  dir_y_e           dir_y_step;
  logic             l_hit, r_hit, l_miss, r_miss;

  frame_tick_gen u_frame_tick_gen (
    .i_CLK   (i_CLK),
    .i_RST   (i_RST),
    .i_vSync (bus.i_vSync),
    .o_tick  (tick)
  );

  assign x_w   = {1'b0, x_q};
  assign y_w   = {1'b0, y_q};
  assign lpy_w = {1'b0, bus.i_left_paddle_y};
  assign rpy_w = {1'b0, bus.i_right_paddle_y};

  // Left face is crossed when x lands in [face, face+SPEED); written without
  // subtraction so small x cannot underflow.
  assign l_hit  = (x_w >= LFACE_C) && (x_w < (LFACE_C + S_C)) &&
                  rows_overlap(y_w, lpy_w, B_C, PH_C);
  assign r_hit  = ((x_w + B_C) <= RFACE_C) && (RFACE_C < (x_w + B_C + S_C)) &&
                  rows_overlap(y_w, rpy_w, B_C, PH_C);
  assign l_miss = (x_w < S_C);
  assign r_miss = ((x_w + B_C + S_C) > W_C);

  // Candidate vertical move with wall clamping for this tick
  always_comb begin
    y_step     = y_q;
    dir_y_step = dir_y_q;
    if (dir_y_q == DIR_DOWN) begin
      if ((y_w + S_C + B_C) >= H_C) begin
        y_step     = 10'(H_C - B_C);
        dir_y_step = DIR_UP;
      end else begin
        y_step     = 10'(y_w + S_C);
        dir_y_step = DIR_DOWN;
      end
    end else begin
      if (y_w < S_C) begin
        y_step     = 10'd0;
        dir_y_step = DIR_DOWN;
      end else begin
        y_step     = 10'(y_w - S_C);
        dir_y_step = DIR_UP;
      end
    end
  end

  // FSM next-state, motion and score-pulse logic
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    cnt_d    = cnt_q;
    lscore_d = 1'b0;
    rscore_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_serve) begin
          state_d = ST_SERVE_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SERVE_WAIT: begin
        if (cnt_q == DELAY_C) begin
          state_d = ST_PLAY;
        end else if (tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end

      ST_PLAY: begin
        if (tick) begin
          // Horizontal: paddle hit outranks miss
          if (dir_x_q == DIR_LEFT) begin
            if (l_hit) begin
              x_d     = 10'(LFACE_C);
              dir_x_d = DIR_RIGHT;
            end else if (l_miss) begin
              rscore_d = 1'b1;
            end else begin
              x_d = 10'(x_w - S_C);
            end
          end else begin
            if (r_hit) begin
              x_d     = RSTOP_C;
              dir_x_d = DIR_LEFT;
            end else if (r_miss) begin
              lscore_d = 1'b1;
            end else begin
              x_d = 10'(x_w + S_C);
            end
          end

          // A miss recentres and serves toward the loser; the y move is dropped
          if (lscore_d || rscore_d) begin
            state_d = ST_IDLE;
            x_d     = X_CTR_C;
            y_d     = Y_CTR_C;
            dir_x_d = rscore_d ? DIR_LEFT : DIR_RIGHT;
            dir_y_d = (dir_y_q == DIR_UP) ? DIR_DOWN : DIR_UP;
          end else begin
            y_d     = y_step;
            dir_y_d = dir_y_step;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, position, direction, counter and score registers
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q  <= ST_IDLE;
      x_q      <= X_CTR_C;
      y_q      <= Y_CTR_C;
      dir_x_q  <= DIR_RIGHT;
      dir_y_q  <= DIR_DOWN;
      cnt_q    <= '0;
      lscore_q <= 1'b0;
      rscore_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      cnt_q    <= cnt_d;
      lscore_q <= lscore_d;
      rscore_q <= rscore_d;
    end
  end

  assign bus.o_ball_x      = x_q;
  assign bus.o_ball_y      = y_q;
  assign bus.o_left_score  = lscore_q;
  assign bus.o_right_score = rscore_q;
  assign bus.o_state       = state_q;

endmodule

// File: tb/tb_ball_controller.sv
// tb_ball_controller
//   Randomised frames (paddle positions, serve requests, vSync timing)
//   checked against a frame-level behavioural model of the Pong ball rules.
module tb_ball_controller;
  import pong_pkg::*;

  localparam int SPEED = 2;
  localparam int DELAY = 3;
  localparam int X_CTR = 312;
  localparam int Y_CTR = 232;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Model state
  int m_x, m_y, m_st, m_cnt;
  bit m_right, m_down;
  int exp_l, exp_r;
  int n_lhit, n_rhit, n_lmiss, n_rmiss, n_wall;

  ball_controller_if bus ();

  ball_controller #(
    .SPEED       (SPEED),
    .SERVE_DELAY (DELAY)
  ) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_x = X_CTR; m_y = Y_CTR; m_right = 1'b1; m_down = 1'b1;
    m_st = 0; m_cnt = 0;
  endfunction

  function automatic void model_serve();
    if (m_st == 0) begin
      m_st  = (DELAY == 0) ? 2 : 1;
      m_cnt = 0;
    end
  endfunction

  function automatic bit overlaps(input int by, input int py);
    return (by + PONG_BALL_SIZE > py) && (by < py + PONG_PADDLE_H);
  endfunction

  // One frame tick of the game rules
  function automatic void model_tick(input int lpy, input int rpy);
    int ny;
    bit nd;
    int lface;
    exp_l = 0; exp_r = 0;
    lface = PONG_LEFT_PADDLE_X + PONG_PADDLE_W;
    if (m_st == 1) begin
      m_cnt++;
      if (m_cnt >= DELAY) m_st = 2;
    end else if (m_st == 2) begin
      if (m_down) begin
        if (m_y + SPEED + PONG_BALL_SIZE >= PONG_SCREEN_H) begin
          ny = PONG_SCREEN_H - PONG_BALL_SIZE; nd = 1'b0; n_wall++;
        end else begin
          ny = m_y + SPEED; nd = 1'b1;
        end
      end else begin
        if (m_y < SPEED) begin
          ny = 0; nd = 1'b1; n_wall++;
        end else begin
          ny = m_y - SPEED; nd = 1'b0;
        end
      end
      if (!m_right) begin
        if (m_x >= lface && m_x - SPEED < lface && overlaps(m_y, lpy)) begin
          m_x = lface; m_right = 1'b1; n_lhit++;
        end else if (m_x < SPEED) begin
          exp_r = 1;
        end else begin
          m_x = m_x - SPEED;
        end
      end else begin
        if (m_x + PONG_BALL_SIZE <= PONG_RIGHT_PADDLE_X &&
            PONG_RIGHT_PADDLE_X < m_x + PONG_BALL_SIZE + SPEED && overlaps(m_y, rpy)) begin
          m_x = PONG_RIGHT_PADDLE_X - PONG_BALL_SIZE; m_right = 1'b0; n_rhit++;
        end else if (m_x + PONG_BALL_SIZE + SPEED > PONG_SCREEN_W) begin
          exp_l = 1;
        end else begin
          m_x = m_x + SPEED;
        end
      end
      if (exp_l != 0 || exp_r != 0) begin
        if (exp_r != 0) n_lmiss++; else n_rmiss++;
        m_right = (exp_l != 0);   // toward the player who lost
        m_x = X_CTR; m_y = Y_CTR; m_down = !m_down; m_st = 0;
      end else begin
        m_y = ny; m_down = nd;
      end
    end
  endfunction

  // Mostly track the ball so rallies happen, sometimes anywhere on 10 bits
  function automatic int pick_paddle();
    int p;
    if ($urandom_range(99, 0) < 65) begin
      p = m_y + 14 - int'($urandom_range(113, 0));
      if (p < 0) p = 0;
    end else begin
      p = int'($urandom_range(1023, 0));
    end
    return p;
  endfunction

  task automatic check_outputs(input string where);
    check_eq({where, "_x"},     int'(bus.o_ball_x), m_x);
    check_eq({where, "_y"},     int'(bus.o_ball_y), m_y);
    check_eq({where, "_state"}, int'(bus.o_state),  m_st);
  endtask

  task automatic do_serve();
    bus.i_serve = 1'b1;
    @(negedge clk);
    bus.i_serve = 1'b0;
    model_serve();
    check_eq("serve_state", int'(bus.o_state), m_st);
  endtask

  task automatic run_frame(input bit allow_serve);
    int lpy, rpy, lo, hi, lcnt, rcnt;
    lpy = pick_paddle();
    rpy = pick_paddle();
    @(negedge clk);
    bus.i_left_paddle_y  = lpy[9:0];
    bus.i_right_paddle_y = rpy[9:0];
    bus.i_vSync          = 1'b0;
    model_tick(lpy, rpy);
    lo = int'($urandom_range(3, 1));
    hi = int'($urandom_range(5, 3));
    lcnt = 0; rcnt = 0;
    repeat (lo) begin
      @(negedge clk);
      lcnt += int'(bus.o_left_score);
      rcnt += int'(bus.o_right_score);
    end
    bus.i_vSync = 1'b1;
    repeat (hi) begin
      @(negedge clk);
      lcnt += int'(bus.o_left_score);
      rcnt += int'(bus.o_right_score);
    end
    check_outputs("frame");
    check_eq("left_score_pulses",  lcnt, exp_l);
    check_eq("right_score_pulses", rcnt, exp_r);
    if (allow_serve && $urandom_range(3, 0) == 0) do_serve();
  endtask

  task automatic check_reset_values(input string where);
    check_eq({where, "_x"},      int'(bus.o_ball_x), X_CTR);
    check_eq({where, "_y"},      int'(bus.o_ball_y), Y_CTR);
    check_eq({where, "_state"},  int'(bus.o_state), 0);
    check_eq({where, "_lscore"}, int'(bus.o_left_score), 0);
    check_eq({where, "_rscore"}, int'(bus.o_right_score), 0);
  endtask

  initial begin
    checks = 0; errors = 0;
    n_lhit = 0; n_rhit = 0; n_lmiss = 0; n_rmiss = 0; n_wall = 0;
    rst = 1'b1;
    bus.i_vSync = 1'b1;
    bus.i_serve = 1'b0;
    bus.i_left_paddle_y  = 10'd0;
    bus.i_right_paddle_y = 10'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Serve, three waiting ticks, then the first move
    do_serve();
    repeat (4) run_frame(1'b0);
    check_eq("first_move_x", int'(bus.o_ball_x), 314);
    check_eq("first_move_y", int'(bus.o_ball_y), 234);

    for (int f = 0; f < 6000; f++) begin
      run_frame(1'b1);
      if (f == 3000) begin
        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
      end
    end

    check_eq("left_paddle_hits_seen",  int'(n_lhit > 0), 1);
    check_eq("right_paddle_hits_seen", int'(n_rhit > 0), 1);
    check_eq("wall_bounces_seen",      int'(n_wall > 0), 1);
    check_eq("misses_seen",            int'((n_lmiss + n_rmiss) > 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
